// File: rtl/laplace_pkg.sv
// Shared constants for the Laplace x-filter frame sequencer: pixel width and FSM state encodings.
package laplace_pkg;

  localparam int unsigned PIX_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_FLUSH  = 2'd3;

endpackage

// File: rtl/laplace_seq_if.sv
// Pixel-in / column-out handshake bundle between the upstream source, laplace_seq and the filter.
interface laplace_seq_if;
  import laplace_pkg::*;

  logic [PIX_W-1:0] i_pixel;
  logic             i_pixel_valid;
  logic             o_pixel_ack;
  logic [PIX_W-1:0] o_col_1;
  logic [PIX_W-1:0] o_col_2;
  logic [PIX_W-1:0] o_col_3;
  logic             o_col_valid;
  logic             i_col_ack;

  modport slave (
    input  i_pixel, i_pixel_valid, i_col_ack,
    output o_pixel_ack, o_col_1, o_col_2, o_col_3, o_col_valid
  );

  modport master (
    output i_pixel, i_pixel_valid, i_col_ack,
    input  o_pixel_ack, o_col_1, o_col_2, o_col_3, o_col_valid
  );

endinterface

// File: rtl/laplace_line_buf.sv
// Two-row line buffer: async read of both rows at one column, write shifts row1 into row0 and stores the new pixel.
module laplace_line_buf
  import laplace_pkg::*;
#(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = 9
)(
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [PIX_W-1:0]  i_pixel,
  output logic [PIX_W-1:0]  o_row0,
  output logic [PIX_W-1:0]  o_row1
);

  logic [PIX_W-1:0] r_lb0 [DEPTH];
  logic [PIX_W-1:0] r_lb1 [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_lb0[i_addr] <= r_lb1[i_addr];
      r_lb1[i_addr] <= i_pixel;
    end
  end

  assign o_row0 = r_lb0[i_addr];
  assign o_row1 = r_lb1[i_addr];

endmodule

// File: rtl/laplace_seq.sv
// Frame sequencer feeding three-row pixel columns to the Laplace x-filter.
// Define LAPLACE_SEQ_BORDER_EN for zero-padded top/bottom rows (adds the FLUSH state).
module laplace_seq
  import laplace_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 512,
  parameter int unsigned IMG_HEIGHT = 512,
  parameter int unsigned COL_W      = 9,
  parameter int unsigned ROW_W      = 9
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  laplace_seq_if.slave     io_px,
  output logic             o_busy,
  output logic             o_done,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
`ifdef LAPLACE_SEQ_BORDER_EN
  localparam logic [ROW_W-1:0] FILL_END_ROW = '0;
`else
  localparam logic [ROW_W-1:0] FILL_END_ROW = ROW_W'(1);
`endif

  logic [1:0]       r_state;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             r_in_last;
  logic             r_valid;
  logic             r_done;
  logic [PIX_W-1:0] r_c1, r_c2, r_c3;

  logic             w_out_free;
  logic             w_col_xfer;
  logic             w_pix_ack;
  logic             w_pix_xfer;
  logic             w_load_stream;
  logic             w_load_flush;
  logic             w_last_col;
  logic [PIX_W-1:0] w_lb0, w_lb1;
  logic [PIX_W-1:0] w_stream_c1;

  laplace_line_buf #(
    .DEPTH  (IMG_WIDTH),
    .ADDR_W (COL_W)
  ) u_line_buf (
    .i_clk   (i_clk),
    .i_we    (w_pix_xfer),
    .i_addr  (r_col),
    .i_pixel (io_px.i_pixel),
    .o_row0  (w_lb0),
    .o_row1  (w_lb1)
  );

  // r_in_last marks "final pixel accepted" in STREAM and "final column loaded" in FLUSH.
  always_comb begin
    w_out_free = ~r_valid | io_px.i_col_ack;
    w_col_xfer = r_valid & io_px.i_col_ack;
    w_pix_ack  = 1'b0;
    case (r_state)
      ST_FILL:   w_pix_ack = 1'b1;
      ST_STREAM: w_pix_ack = w_out_free & ~r_in_last;
      default:   w_pix_ack = 1'b0;
    endcase
    w_pix_xfer    = io_px.i_pixel_valid & w_pix_ack;
    w_load_stream = w_pix_xfer & (r_state == ST_STREAM);
    w_load_flush  = (r_state == ST_FLUSH) & w_out_free & ~r_in_last;
    w_last_col    = (r_col == LAST_COL);
`ifdef LAPLACE_SEQ_BORDER_EN
    w_stream_c1   = (r_row == ROW_W'(1)) ? '0 : w_lb0;
`else
    w_stream_c1   = w_lb0;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_in_last <= 1'b0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_c1      <= '0;
      r_c2      <= '0;
      r_c3      <= '0;
    end else begin
      r_done <= 1'b0;

      if (w_load_stream) begin
        r_valid <= 1'b1;
        r_c1    <= w_stream_c1;
        r_c2    <= w_lb1;
        r_c3    <= io_px.i_pixel;
      end else if (w_load_flush) begin
        r_valid <= 1'b1;
        r_c1    <= w_lb0;
        r_c2    <= w_lb1;
        r_c3    <= '0;
      end else if (w_col_xfer) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state   <= ST_FILL;
            r_row     <= '0;
            r_col     <= '0;
            r_in_last <= 1'b0;
          end
        end
        ST_FILL: begin
          if (w_pix_xfer) begin
            if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
              if (r_row == FILL_END_ROW) r_state <= ST_STREAM;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (w_pix_xfer) begin
            if (w_last_col) begin
              r_col <= '0;
              if (r_row == LAST_ROW) r_in_last <= 1'b1;
              else                   r_row     <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
          if (r_in_last & w_col_xfer) begin
`ifdef LAPLACE_SEQ_BORDER_EN
            r_state   <= ST_FLUSH;
            r_in_last <= 1'b0;
            r_col     <= '0;
`else
            r_state   <= ST_IDLE;
            r_done    <= 1'b1;
            r_row     <= '0;
            r_col     <= '0;
            r_in_last <= 1'b0;
`endif
          end
        end
`ifdef LAPLACE_SEQ_BORDER_EN
        ST_FLUSH: begin
          if (w_load_flush) begin
            if (w_last_col) begin
              r_col     <= '0;
              r_in_last <= 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
          if (r_in_last & w_col_xfer) begin
            r_state   <= ST_IDLE;
            r_done    <= 1'b1;
            r_row     <= '0;
            r_col     <= '0;
            r_in_last <= 1'b0;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_px.o_pixel_ack = w_pix_ack;
  assign io_px.o_col_1     = r_c1;
  assign io_px.o_col_2     = r_c2;
  assign io_px.o_col_3     = r_c3;
  assign io_px.o_col_valid = r_valid;
  assign o_busy            = (r_state != ST_IDLE);
  assign o_done            = r_done;
  assign o_row             = r_row;
  assign o_col             = r_col;

endmodule

// File: tb/tb_laplace_seq.sv
// Scoreboard bench for laplace_seq on a 4x4 frame; expected columns come from a zero-padded neighbourhood model.
module tb_laplace_seq;

  localparam int W = 4;
  localparam int H = 4;
`ifdef LAPLACE_SEQ_BORDER_EN
  localparam int N_COLS = H * W;
`else
  localparam int N_COLS = (H - 2) * W;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done;
  logic [1:0] row, col;

  laplace_seq_if bus();

  laplace_seq #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .COL_W      (2),
    .ROW_W      (2)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .io_px   (bus),
    .o_busy  (busy),
    .o_done  (done),
    .o_row   (row),
    .o_col   (col)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [23:0] exp_q[$];
  int          cols_left = 0;
  int          frame_xfers = 0;
  bit          exp_done = 1'b0;
  int          ack_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Filter-side acknowledge pattern: 0 always high, 1 alternating, 2 random.
  initial begin
    bit tog = 1'b0;
    bus.i_col_ack = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        1:       begin tog = ~tog; bus.i_col_ack = tog; end
        2:       bus.i_col_ack = 1'($urandom_range(0, 1));
        default: bus.i_col_ack = 1'b1;
      endcase
    end
  end

  // Monitor: compares every column transfer against the scoreboard and checks hold/done behaviour.
  initial begin
    bit          held = 1'b0;
    logic [23:0] held_val = '0;
    logic [23:0] cols;
    forever begin
      @(negedge clk);
      cols = {bus.o_col_1, bus.o_col_2, bus.o_col_3};
      if (rst) begin
        held     = 1'b0;
        exp_done = 1'b0;
      end else begin
        if (exp_done) begin
          check("done_pulse_busy", 32'({done, busy}), 32'h2);
          exp_done = 1'b0;
        end else if (done) begin
          check("spurious_done", 32'(done), 32'h0);
        end
        if (held) check("held_column", 32'({bus.o_col_valid, cols}), 32'({1'b1, held_val}));
        if (bus.o_col_valid && !bus.i_col_ack) begin
          check("bp_pixel_ack_low", 32'(bus.o_pixel_ack), 32'h0);
          held     = 1'b1;
          held_val = cols;
        end else begin
          held = 1'b0;
        end
        if (bus.o_col_valid && bus.i_col_ack) begin
          if (exp_q.size() == 0) begin
            check("unexpected_column", 32'(cols), 32'hFFFFFFFF);
          end else begin
            check("column", 32'(cols), 32'(exp_q.pop_front()));
          end
          frame_xfers++;
          cols_left--;
          if (cols_left == 0) exp_done = 1'b1;
        end
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_pixel_ack"}, 32'(bus.o_pixel_ack), 32'h0);
    check({tag, "_col_valid"}, 32'(bus.o_col_valid), 32'h0);
    check({tag, "_col_data"},  32'({bus.o_col_1, bus.o_col_2, bus.o_col_3}), 32'h0);
    check({tag, "_busy"},      32'(busy), 32'h0);
    check({tag, "_done"},      32'(done), 32'h0);
    check({tag, "_row_col"},   32'({row, col}), 32'h0);
  endtask

  task automatic reset_and_check();
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    cols_left = 0;
    rst = 1'b0;
    @(negedge clk);
    check_idle("midreset");
    tick();
  endtask

  // Reference: every output column is the vertical neighbourhood of a centre row, rows outside the frame read as 0.
  task automatic run_frame(input int mode, input bit directed, input int abort_after, input bit start_mid);
    logic [7:0] img [H][W];
    logic [7:0] up, dn;
    bit acc, got_done;
    int n, first_o, last_o;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = directed ? 8'(4 * r + c) : 8'($urandom);
`ifdef LAPLACE_SEQ_BORDER_EN
    first_o = 0;
    last_o  = H - 1;
`else
    first_o = 1;
    last_o  = H - 2;
`endif
    for (int o = first_o; o <= last_o; o++)
      for (int c = 0; c < W; c++) begin
        up = (o == 0)     ? 8'd0 : img[o-1][c];
        dn = (o == H - 1) ? 8'd0 : img[o+1][c];
        exp_q.push_back({up, img[o][c], dn});
      end
    cols_left   = exp_q.size();
    frame_xfers = 0;
    ack_mode    = mode;

    start = 1'b1;
    @(negedge clk);
    check("ack_before_start", 32'(bus.o_pixel_ack), 32'h0);
    tick();
    start = 1'b0;
    @(negedge clk);
    check("ack_after_start", 32'({bus.o_pixel_ack, busy}), 32'h3);
    tick();

    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (!directed && $urandom_range(0, 3) == 0) begin
          bus.i_pixel_valid = 1'b0;
          tick();
        end
        bus.i_pixel       = img[r][c];
        bus.i_pixel_valid = 1'b1;
        start             = start_mid && (r == 2) && (c == 1);
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 64) begin
          @(negedge clk);
          acc = bus.o_pixel_ack;
          tick();
          n++;
          if (abort_after > 0 && frame_xfers >= abort_after) begin
            bus.i_pixel_valid = 1'b0;
            start = 1'b0;
            reset_and_check();
            return;
          end
        end
        start = 1'b0;
        check("pixel_accepted", 32'(acc), 32'h1);
        if (!acc) begin
          bus.i_pixel_valid = 1'b0;
          reset_and_check();
          return;
        end
      end
    end
    bus.i_pixel_valid = 1'b0;

    got_done = 1'b0;
    n = 0;
    while (!got_done && n < 200) begin
      @(negedge clk);
      got_done = done;
      n++;
    end
    check("done_seen", 32'(got_done), 32'h1);
    check("frame_columns", 32'(frame_xfers), 32'(N_COLS));
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.i_pixel = '0;
    bus.i_pixel_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_idle("reset");
    tick();
    rst = 1'b0;
    tick();

    // Valid pixels offered in IDLE must not be acknowledged.
    bus.i_pixel = 8'hA5;
    bus.i_pixel_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle_no_ack", 32'({bus.o_pixel_ack, busy}), 32'h0);
      tick();
    end
    bus.i_pixel_valid = 1'b0;

    run_frame(0, 1'b1, 0, 1'b0);
    run_frame(1, 1'b1, 0, 1'b0);
    run_frame(0, 1'b1, 3, 1'b0);
    run_frame(0, 1'b1, 0, 1'b0);

    run_frame(2, 1'b0, 0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("idle_after_mid_start", 32'({busy, bus.o_pixel_ack}), 32'h0);
      tick();
    end

    run_frame(0, 1'b0, 0, 1'b0);
    run_frame(0, 1'b0, 0, 1'b0);
    for (int k = 0; k < 4; k++) run_frame(2, 1'b0, 0, 1'b0);
    run_frame(1, 1'b0, 0, 1'b0);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
